data_island_packet_tx: RTL and testbench

DATA_ISLAND_PACKET_TX -- requirements
Module: data_island_packet_tx

---
 rtl/data_island_packet_tx.sv | 204 ++++++++++++++++++++
 tb/tb_data_island_packet_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_island_packet_tx.sv
// Data-island packet transmitter: guard bands, serial BCH ECC and TERC4 nibble generation.
// Optional build macro DI_PACKET_LIMIT_EN caps the number of chained packets per island.
module data_island_packet_tx #(
    parameter int unsigned MAX_PACKETS = 18
) (
    input  logic         clk_pixel,
    input  logic         reset_n,
    input  logic         hsync,
    input  logic         vsync,
    input  logic         pkt_valid,
    output logic         pkt_ready,
    input  logic [23:0]  pkt_header,
    input  logic [223:0] pkt_sub,
    output logic [1:0]   di_mode,
    output logic [3:0]   terc4_ch0,
    output logic [3:0]   terc4_ch1,
    output logic [3:0]   terc4_ch2,
    output logic         packet_start
);

    typedef enum logic [1:0] {StIdle, StLeadGb, StData, StTrailGb} state_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             pkt_ready_q, pkt_ready_d;
    logic             accept, permit_d;
    logic [23:0]      header_q, header_d;
    logic [223:0]     sub_q, sub_d;
    logic [7:0]       hecc_q, hecc_d;
    logic [3:0][7:0]  secc_q, secc_d;
    logic [1:0]       di_mode_q, di_mode_d;
    logic [3:0]       ch0_q, ch0_d;
    logic [3:0]       ch1_q, ch1_d;
    logic [3:0]       ch2_q, ch2_d;
    logic             start_q, start_d;
    logic             hbit;
    logic [7:0]       hecc_base, secc_base, sidx;
    logic [3:0]       sbit_even, sbit_odd;

    function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic b);
        logic fb;
        fb = b ^ ecc[0];
        return {1'b0, ecc[7:1]} ^ (fb ? 8'h83 : 8'h00);
    endfunction

    assign accept = pkt_valid && pkt_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StLeadGb;
                    cnt_d   = '0;
                end
            end
            StLeadGb: begin
                if (cnt_q == 5'd1) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StData: begin
                if (cnt_q == 5'd31) begin
                    state_d = accept ? StData : StTrailGb;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StTrailGb: begin
                if (cnt_q == 5'd1) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DI_PACKET_LIMIT_EN
    localparam int unsigned CntW = $clog2(MAX_PACKETS + 1);

    logic [CntW-1:0] pkt_num_q, pkt_num_d;

    always_comb begin
        pkt_num_d = pkt_num_q;
        if (state_d == StIdle) begin
            pkt_num_d = '0;
        end else if (accept) begin
            pkt_num_d = pkt_num_q + CntW'(1);
        end
        permit_d = (32'(pkt_num_d) < MAX_PACKETS);
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            pkt_num_q <= '0;
        end else begin
            pkt_num_q <= pkt_num_d;
        end
    end
`else
    assign permit_d = 1'b1;
`endif

    // pkt_ready is registered from the next state so it lines up with the state register.
    assign pkt_ready_d = (state_d == StIdle) ||
                         ((state_d == StData) && (cnt_d == 5'd31) && permit_d);
    assign header_d    = accept ? pkt_header : header_q;
    assign sub_d       = accept ? pkt_sub : sub_q;

    always_comb begin
        di_mode_d = 2'd0;
        ch0_d     = 4'd0;
        start_d   = 1'b0;
        hecc_d    = hecc_q;
        secc_d    = secc_q;
        hbit      = 1'b0;
        hecc_base = 8'd0;
        secc_base = 8'd0;
        sidx      = 8'd0;
        sbit_even = 4'd0;
        sbit_odd  = 4'd0;
        unique case (state_q)
            StLeadGb, StTrailGb: begin
                di_mode_d = 2'd1;
                ch0_d     = {2'b11, vsync, hsync};
            end
            StData: begin
                di_mode_d = 2'd2;
                start_d   = (cnt_q == 5'd0);
                hbit      = (cnt_q < 5'd24) ? header_q[cnt_q] : hecc_q[cnt_q[2:0]];
                ch0_d     = {(cnt_q != 5'd0), hbit, vsync, hsync};
                // Cycle 0 restarts every ECC from zero, discarding any earlier residue.
                hecc_base = (cnt_q == 5'd0) ? 8'd0 : hecc_q;
                if (cnt_q < 5'd24) begin
                    hecc_d = ecc_step(hecc_base, hbit);
                end
                for (int k = 0; k < 4; k++) begin
                    secc_base = (cnt_q == 5'd0) ? 8'd0 : secc_q[k];
                    if (cnt_q < 5'd28) begin
                        sidx         = 8'(56 * k) + {2'b00, cnt_q, 1'b0};
                        sbit_even[k] = sub_q[sidx];
                        sbit_odd[k]  = sub_q[sidx + 8'd1];
                        secc_d[k]    = ecc_step(ecc_step(secc_base, sbit_even[k]), sbit_odd[k]);
                    end else begin
                        sbit_even[k] = secc_q[k][{cnt_q[1:0], 1'b0}];
                        sbit_odd[k]  = secc_q[k][{cnt_q[1:0], 1'b1}];
                    end
                end
            end
            default: ;
        endcase
        ch1_d = sbit_even;
        ch2_d = sbit_odd;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pkt_ready_q <= 1'b0;
            header_q    <= '0;
            sub_q       <= '0;
            hecc_q      <= '0;
            secc_q      <= '0;
            di_mode_q   <= '0;
            ch0_q       <= '0;
            ch1_q       <= '0;
            ch2_q       <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pkt_ready_q <= pkt_ready_d;
            header_q    <= header_d;
            sub_q       <= sub_d;
            hecc_q      <= hecc_d;
            secc_q      <= secc_d;
            di_mode_q   <= di_mode_d;
            ch0_q       <= ch0_d;
            ch1_q       <= ch1_d;
            ch2_q       <= ch2_d;
            start_q     <= start_d;
        end
    end

    assign pkt_ready    = pkt_ready_q;
    assign di_mode      = di_mode_q;
    assign terc4_ch0    = ch0_q;
    assign terc4_ch1    = ch1_q;
    assign terc4_ch2    = ch2_q;
    assign packet_start = start_q;

endmodule

// File: tb/tb_data_island_packet_tx.sv
// Directed bench for data_island_packet_tx; the chain test becomes a packet-limit test
// when DI_PACKET_LIMIT_EN is defined (DUT built with MAX_PACKETS=2).
module tb_data_island_packet_tx;

    logic         clk_pixel = 1'b0;
    logic         reset_n;
    logic         hsync, vsync, pkt_valid, pkt_ready;
    logic [23:0]  pkt_header;
    logic [223:0] pkt_sub;
    logic [1:0]   di_mode;
    logic [3:0]   terc4_ch0, terc4_ch1, terc4_ch2;
    logic         packet_start;

    int   errors = 0;
    int   checks = 0;
    logic wiggle = 1'b0;

    data_island_packet_tx #(.MAX_PACKETS(2)) dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .hsync        (hsync),
        .vsync        (vsync),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_header   (pkt_header),
        .pkt_sub      (pkt_sub),
        .di_mode      (di_mode),
        .terc4_ch0    (terc4_ch0),
        .terc4_ch1    (terc4_ch1),
        .terc4_ch2    (terc4_ch2),
        .packet_start (packet_start)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serial BCH over the first n bits of the vector, bit 0 first.
    function automatic logic [7:0] bch(input logic [55:0] bits, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'd0;
        for (int i = 0; i < n; i++) begin
            fb = bits[i] ^ e[0];
            e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    function automatic logic [14:0] out_word();
        return {di_mode, terc4_ch0, terc4_ch1, terc4_ch2, packet_start};
    endfunction

    function automatic logic [14:0] data_w(input int c, input logic [23:0] h,
                                           input logic [223:0] s, input logic hs, input logic vs);
        logic [31:0] hst;
        logic [55:0] sk;
        logic [63:0] st;
        logic [3:0]  c1, c2;
        hst = {bch({32'd0, h}, 24), h};
        for (int k = 0; k < 4; k++) begin
            sk    = s[56*k +: 56];
            st    = {bch(sk, 56), sk};
            c1[k] = st[2*c];
            c2[k] = st[2*c+1];
        end
        return {2'd2, (c != 0), hst[c], vs, hs, c1, c2, (c == 0)};
    endfunction

    // kind: 0 idle, 1 guard band, 2 data cycle c of packet (h, s).
    task automatic step_expect(input string tag, input int kind, input int c,
                               input logic [23:0] h, input logic [223:0] s);
        logic [14:0] exp;
        @(negedge clk_pixel);
        case (kind)
            0:       exp = 15'd0;
            1:       exp = {2'd1, 2'b11, vsync, hsync, 8'd0, 1'b0};
            default: exp = data_w(c, h, s, hsync, vsync);
        endcase
        check_eq(tag, 32'(out_word()), 32'(exp));
        if (wiggle) {vsync, hsync} = {vsync, hsync} + 2'd1;
    endtask

    task automatic expect_gb2(input string tag);
        step_expect(tag, 1, 0, 24'd0, 224'd0);
        step_expect(tag, 1, 0, 24'd0, 224'd0);
    endtask

    task automatic expect_data(input string tag, input logic [23:0] h, input logic [223:0] s,
                               input logic ready30, output logic [7:0] hecc_obs);
        hecc_obs = 8'd0;
        for (int c = 0; c < 32; c++) begin
            step_expect(tag, 2, c, h, s);
            if (c >= 24) hecc_obs[c-24] = terc4_ch0[2];
            if (c == 5)  check_eq({tag, "_rdy5"}, 32'(pkt_ready), 32'd0);
            if (c == 30) check_eq({tag, "_rdy31"}, 32'(pkt_ready), 32'(ready30));
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!pkt_ready && n < 100) begin
            @(negedge clk_pixel);
            n++;
        end
        check_eq({tag, "_rdy_wait"}, 32'(pkt_ready), 32'd1);
    endtask

    task automatic offer(input string tag, input logic [23:0] h, input logic [223:0] s);
        wait_ready(tag);
        pkt_header = h;
        pkt_sub    = s;
        pkt_valid  = 1'b1;
        step_expect({tag, "_acc"}, 0, 0, h, s);
        pkt_valid  = 1'b0;
        pkt_header = ~h;
        pkt_sub    = ~s;
    endtask

    task automatic rand_sub(output logic [223:0] s);
        for (int i = 0; i < 7; i++) s[32*i +: 32] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]   obs;
        logic [23:0]  h0, h1, h2;
        logic [223:0] s0, s1, s2;

        reset_n    = 1'b0;
        hsync      = 1'b0;
        vsync      = 1'b0;
        pkt_valid  = 1'b0;
        pkt_header = 24'd0;
        pkt_sub    = 224'd0;

        // Reset state and first pkt_ready one cycle after release.
        #12;
        check_eq("rst_word", 32'(out_word()), 32'd0);
        check_eq("rst_ready", 32'(pkt_ready), 32'd0);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        #1;
        check_eq("rdy_release", 32'(pkt_ready), 32'd0);
        @(negedge clk_pixel);
        check_eq("rdy_first", 32'(pkt_ready), 32'd1);
        check_eq("idle_word", 32'(out_word()), 32'd0);

        // All-zero packet; a valid held through trailing guard band must not start a packet.
        hsync = 1'b1;
        offer("zero", 24'd0, 224'd0);
        expect_gb2("zero_lgb");
        expect_data("zero", 24'd0, 224'd0, 1'b1, obs);
        step_expect("zero_tgb", 1, 0, 24'd0, 224'd0);
        check_eq("zero_tgb_rdy", 32'(pkt_ready), 32'd0);
        pkt_valid = 1'b1;
        step_expect("zero_tgb", 1, 0, 24'd0, 224'd0);
        check_eq("zero_idle_rdy", 32'(pkt_ready), 32'd1);
        pkt_valid = 1'b0;
        step_expect("zero_idle", 0, 0, 24'd0, 224'd0);
        step_expect("zero_idle", 0, 0, 24'd0, 224'd0);

        // Header 000001 with random subpackets, syncs changing every cycle.
        rand_sub(s0);
        wiggle = 1'b1;
        offer("rnd", 24'h000001, s0);
        expect_gb2("rnd_lgb");
        expect_data("rnd", 24'h000001, s0, 1'b1, obs);
        check_eq("rnd_hecc", 32'(obs), 32'h4A);
        expect_gb2("rnd_tgb");
        step_expect("rnd_idle", 0, 0, 24'd0, 224'd0);
        wiggle = 1'b0;

        // Reset at data cycle 10, then a clean packet.
        rand_sub(s1);
        offer("rst", 24'hA5C33C, s1);
        expect_gb2("rst_lgb");
        for (int c = 0; c <= 10; c++) step_expect("rst_pre", 2, c, 24'hA5C33C, s1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_word", 32'(out_word()), 32'd0);
        check_eq("rst_mid_rdy", 32'(pkt_ready), 32'd0);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        check_eq("rst_rel_word", 32'(out_word()), 32'd0);
        @(negedge clk_pixel);
        check_eq("rst_after_rdy", 32'(pkt_ready), 32'd1);
        check_eq("rst_after_word", 32'(out_word()), 32'd0);
        rand_sub(s2);
        offer("post", 24'h3C5A96, s2);
        expect_gb2("post_lgb");
        expect_data("post", 24'h3C5A96, s2, 1'b1, obs);
        expect_gb2("post_tgb");
        step_expect("post_idle", 0, 0, 24'd0, 224'd0);

        h0 = 24'h123456;
        h1 = 24'hFEDCBA;
        h2 = 24'h0F0F0F;
        rand_sub(s0);
        rand_sub(s1);
        rand_sub(s2);
        wait_ready("chain");
        pkt_header = h0;
        pkt_sub    = s0;
        pkt_valid  = 1'b1;
        step_expect("chain_acc", 0, 0, h0, s0);
        pkt_header = h1;
        pkt_sub    = s1;
        expect_gb2("chain_lgb");
`ifdef DI_PACKET_LIMIT_EN
        expect_data("lim0", h0, s0, 1'b1, obs);
        pkt_header = h2;
        pkt_sub    = s2;
        expect_data("lim1", h1, s1, 1'b0, obs);
        expect_gb2("lim_tgb");
        step_expect("lim_idle", 0, 0, 24'd0, 224'd0);
        pkt_valid  = 1'b0;
        pkt_header = 24'd0;
        pkt_sub    = 224'd0;
        expect_gb2("lim_lgb2");
        expect_data("lim2", h2, s2, 1'b1, obs);
`else
        expect_data("chain0", h0, s0, 1'b1, obs);
        pkt_header = h2;
        pkt_sub    = s2;
        expect_data("chain1", h1, s1, 1'b1, obs);
        pkt_valid  = 1'b0;
        pkt_header = 24'd0;
        pkt_sub    = 224'd0;
        expect_data("chain2", h2, s2, 1'b1, obs);
`endif
        expect_gb2("chain_tgb");
        step_expect("chain_idle", 0, 0, 24'd0, 224'd0);
        step_expect("chain_idle", 0, 0, 24'd0, 224'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
